// File: rtl/pla_bench_pkg.sv
// Shared types and constants for the PLA sweep/signature harness.
// Latency: none (declarations only).
// Backpressure: not applicable.
package pla_bench_pkg;

  // Harness sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // CRC-16/CCITT feedback taps; the x^16 term is implicit.
  localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;

  localparam int SIG_W_DEFAULT = 16;

endpackage

// File: rtl/sig_misr.sv
// Serial CRC accumulator: shifts one data bit per enabled clock into a Galois-form CRC.
// Latency: sig reflects din one clock after the enabled edge.
// Backpressure: none; en qualifies each bit, load has priority over en.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset (sig -> RST_VAL)
//   load, seed  synchronous load of seed into the register
//   en, din     accumulate din when en is high
//   sig         current signature
module sig_misr
  import pla_bench_pkg::*;
#(
  parameter int               SIG_W    = SIG_W_DEFAULT,
  parameter logic [SIG_W-1:0] SIG_POLY = SIG_W'(CRC16_CCITT_POLY),
  parameter logic [SIG_W-1:0] RST_VAL  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [SIG_W-1:0] seed,
  input  logic             en,
  input  logic             din,
  output logic [SIG_W-1:0] sig
);

  // Feedback is the outgoing MSB mixed with the incoming bit.
  logic fb;
  assign fb = sig[SIG_W-1] ^ din;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= RST_VAL;
    end else if (load) begin
      sig <= seed;
    end else if (en) begin
      sig <= {sig[SIG_W-2:0], 1'b0} ^ (fb ? SIG_POLY : '0);
    end
  end

endmodule

// File: rtl/pla_sweep_signature.sv
// Drives an exhaustive input sweep into a PLA netlist and compacts its output into a CRC + ones count.
// Latency: start at E0, issues on E1..E(2^N_IN), done after E(2^N_IN+DUT_LAT).
// Backpressure: pause freezes pattern issue; in-flight results still retire; abort flushes to IDLE.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, pause, abort control (abort overrides start)
//   x_vec               registered pattern to netlist; y_in is netlist output
//   busy, done          SWEEP/DRAIN and DONE indicators
//   ones_cnt, signature captured-ones count and CRC of the captured y_in stream
module pla_sweep_signature
  import pla_bench_pkg::*;
#(
  parameter int               N_IN     = 14,
  parameter int               DUT_LAT  = 0,
  parameter int               SIG_W    = SIG_W_DEFAULT,
  parameter logic [SIG_W-1:0] SIG_POLY = SIG_W'(CRC16_CCITT_POLY),
  parameter logic [SIG_W-1:0] SIG_SEED = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              pause,
  input  logic              abort,
  output logic [N_IN-1:0]   x_vec,
  input  logic              y_in,
  output logic              busy,
  output logic              done,
  output logic [N_IN:0]     ones_cnt,
  output logic [SIG_W-1:0]  signature
);

  localparam logic [N_IN-1:0] X_MAX = '1;

  state_t state;

  logic accept_start;
  logic issue;
  logic cap;
  logic drain_empty;

  assign accept_start = start && !abort && ((state == IDLE) || (state == DONE));
  assign issue        = (state == SWEEP) && !pause && !abort;

  generate
    if (DUT_LAT == 0) begin : g_nopipe
      // Combinational netlist: y_in already belongs to the pattern being issued.
      assign cap         = issue;
      assign drain_empty = 1'b1;
    end else begin : g_pipe
      logic [DUT_LAT-1:0] vpipe;
      logic [DUT_LAT-1:0] vpipe_nxt;

      // Bit 0 marks a pattern issued this edge; the MSB marks a result arriving now.
      assign vpipe_nxt   = (vpipe << 1) | DUT_LAT'(issue);
      assign cap         = vpipe[DUT_LAT-1] && !abort;
      // Last capture of the drain: nothing else remains in flight after this edge.
      assign drain_empty = (vpipe_nxt == '0);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vpipe <= '0;
        end else if (abort) begin
          vpipe <= '0;
        end else begin
          vpipe <= vpipe_nxt;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      x_vec    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ones_cnt <= '0;
    end else if (abort) begin
      // Results are deliberately left visible after an abort.
      state <= IDLE;
      x_vec <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      if (accept_start) begin
        ones_cnt <= '0;
      end else if (cap) begin
        ones_cnt <= ones_cnt + (N_IN+1)'(y_in);
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= SWEEP;
            x_vec <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
        SWEEP: begin
          if (issue) begin
            // Wraps to 0 on the final issue and stays there afterwards.
            x_vec <= x_vec + 1'b1;
            if (x_vec == X_MAX) begin
              if (DUT_LAT == 0) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state <= DRAIN;
              end
            end
          end
        end
        DRAIN: begin
          if (cap && drain_empty) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sig_misr #(
    .SIG_W   (SIG_W),
    .SIG_POLY(SIG_POLY),
    .RST_VAL (SIG_SEED)
  ) u_misr (
    .clk  (clk),
    .rst_n(rst_n),
    .load (accept_start),
    .seed (SIG_SEED),
    .en   (cap),
    .din  (y_in),
    .sig  (signature)
  );

endmodule

// File: tb/tb_pla_sweep_signature.sv
// Directed bench for pla_sweep_signature with three instances (netlist latency 0, 1 and 3).
// Latency: checks exact done timing relative to the start edge for each latency.
// Backpressure: exercises pause, abort, ignored starts and asynchronous reset mid-drain.
module tb_pla_sweep_signature;

  logic clk;
  logic rst_n;

  logic start0, pause0, abort0, y0_val;
  logic start1, pause1, abort1, y1;
  logic start3, pause3, abort3, y3;
  logic p1, p2;

  logic [13:0] x0, x1, x3;
  logic        busy0, busy1, busy3;
  logic        done0, done1, done3;
  logic [14:0] ones0, ones1, ones3;
  logic [15:0] sig0, sig1, sig3;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_ones_sig;
  logic [15:0] exp_x0_sig;
  logic [15:0] exp_x05_sig;

  pla_sweep_signature #(.DUT_LAT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .pause(pause0), .abort(abort0),
    .x_vec(x0), .y_in(y0_val), .busy(busy0), .done(done0),
    .ones_cnt(ones0), .signature(sig0)
  );

  pla_sweep_signature #(.DUT_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .pause(pause1), .abort(abort1),
    .x_vec(x1), .y_in(y1), .busy(busy1), .done(done1),
    .ones_cnt(ones1), .signature(sig1)
  );

  pla_sweep_signature #(.DUT_LAT(3)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .pause(pause3), .abort(abort3),
    .x_vec(x3), .y_in(y3), .busy(busy3), .done(done3),
    .ones_cnt(ones3), .signature(sig3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Netlist models: one-register y = x0, three-register y = x0 ^ x5.
  always @(posedge clk) begin
    y1 <= x1[0];
    p1 <= x3[0] ^ x3[5];
    p2 <= p1;
    y3 <= p2;
  end

  // Reference CRC over the full pattern order: 1 = constant one, 2 = x0, 3 = x0^x5.
  function automatic logic [15:0] crc_model(input int mode);
    logic [15:0] s;
    logic        b;
    s = 16'h0000;
    for (int i = 0; i < 16384; i++) begin
      case (mode)
        1:       b = 1'b1;
        2:       b = i[0];
        default: b = i[0] ^ i[5];
      endcase
      if (s[15] ^ b) s = {s[14:0], 1'b0} ^ 16'h1021;
      else           s = {s[14:0], 1'b0};
    end
    return s;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    start0 = 1'b0; pause0 = 1'b0; abort0 = 1'b0; y0_val = 1'b0;
    start1 = 1'b0; pause1 = 1'b0; abort1 = 1'b0;
    start3 = 1'b0; pause3 = 1'b0; abort3 = 1'b0;

    exp_ones_sig = crc_model(1);
    exp_x0_sig   = crc_model(2);
    exp_x05_sig  = crc_model(3);

    #12;
    check("rst_x0",    x0, 0);
    check("rst_busy0", busy0, 0);
    check("rst_done0", done0, 0);
    check("rst_ones0", ones0, 0);
    check("rst_sig0",  sig0, 0);
    check("rst_busy3", busy3, 0);
    check("rst_x3",    x3, 0);
    rst_n = 1'b1;

    // Phase A: L0 with y=0, L1 with y=x0, L3 aborted at 0x0800 then restarted.
    @(posedge clk); #1;
    start0 = 1'b1; start1 = 1'b1; start3 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0; start3 = 1'b0;
    check("a_e0_busy0", busy0, 1);
    check("a_e0_x0",    x0, 0);
    check("a_e0_done0", done0, 0);

    for (int k = 1; k <= 18440; k++) begin
      @(posedge clk); #1;
      if (k == 100)  check("a_x0_100", x0, 100);
      if (k == 2048) begin
        check("a_x3_0800", x3, 14'h0800);
        abort3 = 1'b1;
      end
      if (k == 2049) begin
        abort3 = 1'b0;
        check("abort_busy3", busy3, 0);
        check("abort_done3", done3, 0);
        check("abort_x3",    x3, 0);
        check("abort_ones3", ones3, 1023);
      end
      if (k == 2050) begin
        check("abort_hold_ones3", ones3, 1023);
        start3 = 1'b1;
        start0 = 1'b1;
      end
      if (k == 2051) begin
        start3 = 1'b0;
        start0 = 1'b0;
        check("sweep_start_ignored_x0", x0, 2051);
        check("restart_x3", x3, 0);
        check("restart_ones3", ones3, 0);
      end
      if (k == 16383) check("l0_done_early", done0, 0);
      if (k == 16384) begin
        check("l0_done",       done0, 1);
        check("l0_busy_off",   busy0, 0);
        check("l0_x_wrap",     x0, 0);
        check("l1_drain_busy", busy1, 1);
        check("l1_drain_done", done1, 0);
        check("l1_x_wrap",     x1, 0);
      end
      if (k == 16385) check("l1_done", done1, 1);
      if (k == 18437) check("l3_done_early", done3, 0);
      if (k == 18438) check("l3_done", done3, 1);
    end

    check("t1_ones0", ones0, 0);
    check("t1_sig0",  sig0, 16'h0000);
    check("t1_done0_held", done0, 1);
    check("t3_ones1", ones1, 8192);
    check("t3_sig1",  sig1, exp_x0_sig);
    check("t5_ones3", ones3, 8192);
    check("t5_sig3",  sig3, exp_x05_sig);

    // Phase B: L0 with y=1, L1 paused at 0x1234, L3 reset asynchronously mid-drain.
    y0_val = 1'b1;
    start0 = 1'b1; start1 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0;
    check("b_e0_done0_clr", done0, 0);
    check("b_e0_ones0_clr", ones0, 0);

    for (int k = 1; k <= 16586; k++) begin
      @(posedge clk); #1;
      if (k == 199) start3 = 1'b1;
      if (k == 200) begin
        start3 = 1'b0;
        check("b_l3_busy", busy3, 1);
        check("b_l3_done_clr", done3, 0);
        check("b_l3_x", x3, 0);
      end
      if (k == 4660) begin
        check("pause_x1_start", x1, 14'h1234);
        pause1 = 1'b1;
      end
      if (k == 4700) check("pause_x1_mid", x1, 14'h1234);
      if (k == 4760) begin
        check("pause_x1_end", x1, 14'h1234);
        check("pause_busy1", busy1, 1);
        pause1 = 1'b0;
      end
      if (k == 4761) check("pause_x1_resume", x1, 14'h1235);
      if (k == 16384) begin
        check("t2_done0", done0, 1);
        check("t2_ones0", ones0, 15'h4000);
        check("t2_sig0",  sig0, exp_ones_sig);
      end
      if (k == 16484) check("t4_done1_early", done1, 0);
      if (k == 16485) begin
        check("t4_done1", done1, 1);
        check("t4_ones1", ones1, 8192);
        check("t4_sig1",  sig1, exp_x0_sig);
      end
      if (k == 16585) begin
        check("drain_busy3", busy3, 1);
        check("drain_done3", done3, 0);
        start3 = 1'b1;
      end
      if (k == 16586) begin
        start3 = 1'b0;
        check("drain_start_ignored_busy", busy3, 1);
        check("drain_start_ignored_ones", ones3, 8192);
        check("drain_done3_still0", done3, 0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy3", busy3, 0);
        check("arst_done3", done3, 0);
        check("arst_x3",    x3, 0);
        check("arst_ones3", ones3, 0);
        check("arst_sig3",  sig3, 0);
        check("arst_done0", done0, 0);
        check("arst_sig1",  sig1, 0);
      end
    end

    @(posedge clk); #1;
    check("arst_hold_done3", done3, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_busy3", busy3, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
